// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset defaults, FSM state and buffer entry type
// for the instruction-fetch requester (ifetch_ctrl / ifetch_buf).
// Build option: IFETCH_BUF2_EN selects the 2-entry response buffer.
package ifetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] DEF_PC_STEP  = 32'd4;

   // BOOT is a one-cycle settling state: the first response after reset or a
   // redirect may belong to an address issued before the event.
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   // Instruction fetches are word aligned; low address bits are ignored.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
      return {pc[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: response buffer between the memory side and decode, with flush.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: o_full tells the writer to stop; head holds until i_pop.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_flush                 drop all entries (wins over push and pop)
//   i_push, i_push_instr/pc write one {instr, pc} entry
//   i_pop                   consume the head entry
//   o_full                  no free slot
//   o_head_vld              buffer not empty (head valid)
//   o_head_instr/pc         head entry, driven straight from registers
//
// Depth: 2 when IFETCH_BUF2_EN is defined, otherwise 1.
module ifetch_buf
   import ifetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [INSTR_W-1:0] i_push_instr,
   input  logic [ADDR_W-1:0]  i_push_pc,
   input  logic               i_pop,
   output logic               o_full,
   output logic               o_head_vld,
   output logic [INSTR_W-1:0] o_head_instr,
   output logic [ADDR_W-1:0]  o_head_pc
);

   entry_t w_din;
   assign w_din = {i_push_instr, i_push_pc};

   // Entry 0 is always the head so the outputs come directly from flops.
   entry_t r_ent0;
   logic   r_vld0;

`ifdef IFETCH_BUF2_EN
   entry_t r_ent1;
   logic   r_vld1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld0 <= 1'b0;
         r_vld1 <= 1'b0;
         r_ent0 <= '0;
         r_ent1 <= '0;
      end else if (i_flush) begin
         r_vld0 <= 1'b0;
         r_vld1 <= 1'b0;
      end else begin
         case ({i_push, i_pop})
            2'b11: begin
               // Pop and push together: the queue shifts by one.
               if (r_vld1) begin
                  r_ent0 <= r_ent1;
                  r_ent1 <= w_din;
               end else begin
                  r_ent0 <= w_din;
                  r_vld0 <= 1'b1;
               end
            end
            2'b10: begin
               if (!r_vld0) begin
                  r_ent0 <= w_din;
                  r_vld0 <= 1'b1;
               end else begin
                  r_ent1 <= w_din;
                  r_vld1 <= 1'b1;
               end
            end
            2'b01: begin
               r_ent0 <= r_ent1;
               r_vld0 <= r_vld1;
               r_vld1 <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_full = r_vld1;
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld0 <= 1'b0;
         r_ent0 <= '0;
      end else if (i_flush) begin
         r_vld0 <= 1'b0;
      end else if (i_push) begin
         // Writer only pushes when empty or popping this cycle.
         r_ent0 <= w_din;
         r_vld0 <= 1'b1;
      end else if (i_pop) begin
         r_vld0 <= 1'b0;
      end
   end

   assign o_full = r_vld0;
`endif

   assign o_head_vld   = r_vld0;
   assign o_head_instr = r_ent0.instr;
   assign o_head_pc    = r_ent0.pc;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: chooses the PC presented to a free-running instruction memory,
// tags returned words with their address and hands them to decode.
// Latency: instr_valid rises the cycle after the accepting edge; backpressure:
// decode stall fills the buffer, further responses are dropped and re-fetched.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   fetch_en                       0 freezes mem_pc and drops responses
//   mem_pc                         registered fetch address
//   mem_rdy, mem_instr             response strobe/word for last cycle's mem_pc
//   redirect_valid, redirect_pc    one-cycle jump request and target
//   instr_valid/ready, instr, instr_pc   decode handshake and head entry
//
// Build option: IFETCH_BUF2_EN gives a 2-entry buffer (default 1 entry).
module ifetch_ctrl
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter logic [ADDR_W-1:0] PC_STEP  = DEF_PC_STEP
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   output logic [ADDR_W-1:0]  mem_pc,
   input  logic               mem_rdy,
   input  logic [INSTR_W-1:0] mem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_mem_pc;
   logic [ADDR_W-1:0] r_prev_pc;
   logic              r_prev_vld;

   logic w_full;
   logic w_head_vld;
   logic w_pop;
   logic w_push;

   assign w_pop = w_head_vld & instr_ready;

   // A strobe belongs to the address presented one cycle earlier (r_prev_pc).
   // Accept only if that is still the address we want, i.e. mem_pc has not
   // moved since; otherwise the word is stale and the address is re-fetched.
   assign w_push = (r_state == ST_RUN) & fetch_en & mem_rdy & r_prev_vld &
                   (r_prev_pc == r_mem_pc) & ~redirect_valid &
                   (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_mem_pc   <= RESET_PC;
         r_prev_pc  <= RESET_PC;
         r_prev_vld <= 1'b0;
      end else begin
         r_prev_pc <= r_mem_pc;
         if (redirect_valid) begin
            r_state    <= ST_BOOT;
            r_mem_pc   <= align_pc(redirect_pc);
            r_prev_vld <= 1'b0;
         end else begin
            case (r_state)
               ST_BOOT: begin
                  r_state    <= ST_RUN;
                  r_prev_vld <= 1'b1;
               end
               ST_RUN: begin
                  if (w_push) begin
                     r_mem_pc <= r_mem_pc + PC_STEP;
                  end
               end
               default: r_state <= ST_BOOT;
            endcase
         end
      end
   end

   ifetch_buf u_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (redirect_valid),
      .i_push       (w_push),
      .i_push_instr (mem_instr),
      .i_push_pc    (r_mem_pc),
      .i_pop        (w_pop),
      .o_full       (w_full),
      .o_head_vld   (w_head_vld),
      .o_head_instr (instr),
      .o_head_pc    (instr_pc)
   );

   assign mem_pc      = r_mem_pc;
   assign instr_valid = w_head_vld;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed bench for ifetch_ctrl with a free-running memory
// model (one response every 2 cycles for the PC sampled one cycle earlier)
// and a scoreboard of expected {instr, pc} deliveries plus point probes.
module tb_ifetch_ctrl;

`ifdef IFETCH_BUF2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   localparam int P_MEMPC  = 0;
   localparam int P_VLD    = 1;
   localparam int P_INSTR  = 2;
   localparam int P_IPC    = 3;
   localparam int P_LAT    = 4;
   localparam int P_TMO    = 5;
   localparam int P_QEMPTY = 6;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } sb_t;

   typedef struct {
      int          sig;
      logic [31:0] exp;
      int          act;
      string       name;
   } probe_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] mem_pc;
   logic        mem_rdy = 1'b0;
   logic [31:0] mem_instr = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   sb_t    exp_q[$];
   probe_t pq[$];
   int     n_cmp = 0;
   int     n_bad = 0;

   always #5 clk = ~clk;

   ifetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .mem_pc         (mem_pc),
      .mem_rdy        (mem_rdy),
      .mem_instr      (mem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   // Memory image: byte at address a is a[7:0]; big-endian word assembly.
   function automatic logic [31:0] word(input logic [31:0] pc);
      logic [7:0] b;
      b = pc[7:0];
      return {b, b + 8'd1, b + 8'd2, b + 8'd3};
   endfunction

   // Free-running memory, not reset: samples mem_pc every other edge and
   // strobes the matching word for one cycle.
   logic mem_phase = 1'b1;
   always @(posedge clk) begin
      mem_phase <= ~mem_phase;
      if (mem_phase) begin
         mem_rdy   <= 1'b1;
         mem_instr <= word(mem_pc);
      end else begin
         mem_rdy   <= 1'b0;
      end
   end

   // ---------------- monitor / checker ----------------
   probe_t      m_p;
   sb_t         m_e;
   logic [31:0] m_act;
   logic        m_ok;

   always @(negedge clk) begin
      while (pq.size() > 0) begin
         m_p = pq.pop_front();
         case (m_p.sig)
            P_MEMPC:  m_act = mem_pc;
            P_VLD:    m_act = {31'b0, instr_valid};
            P_INSTR:  m_act = instr;
            P_IPC:    m_act = instr_pc;
            P_QEMPTY: m_act = 32'(exp_q.size());
            default:  m_act = 32'(m_p.act);
         endcase
         if (m_p.sig == P_LAT)      m_ok = (m_act <= m_p.exp);
         else if (m_p.sig == P_TMO) m_ok = 1'b0;
         else                       m_ok = (m_act === m_p.exp);
         n_cmp++;
         if (!m_ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required %s0x%08h", m_p.name, m_act,
                     (m_p.sig == P_LAT) ? "<= " : "", m_p.exp);
         end
      end
      if (rst_n && !redirect_valid && instr_valid && instr_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL delivery: got pc=0x%08h instr=0x%08h, required none", instr_pc, instr);
         end else begin
            m_e = exp_q.pop_front();
            if (instr_pc !== m_e.pc || instr !== m_e.instr) begin
               n_bad++;
               $display("FAIL delivery: got pc=0x%08h instr=0x%08h, required pc=0x%08h instr=0x%08h",
                        instr_pc, instr, m_e.pc, m_e.instr);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int sig, input logic [31:0] exp, input string nm);
      probe_t p;
      p.sig = sig; p.exp = exp; p.act = 0; p.name = nm;
      pq.push_back(p);
   endtask

   task automatic exp_push(input logic [31:0] pc);
      exp_q.push_back({word(pc), pc});
   endtask

   // Run with instr_ready high until the given pc is at the head, then stall.
   task automatic wait_head(input logic [31:0] pc, input string nm);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (instr_valid && instr_pc == pc) begin
            instr_ready = 1'b0;
            return;
         end
      end
      instr_ready = 1'b0;
      probe(P_TMO, pc, nm);
   endtask

   // Counts edges since the triggering edge until instr_valid is seen.
   task automatic wait_first(input string nm);
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (instr_valid) begin
            probe_t p;
            p.sig = P_LAT; p.exp = 32'd4; p.act = n; p.name = nm;
            pq.push_back(p);
            return;
         end
      end
      probe(P_TMO, 32'd4, nm);
   endtask

   initial begin
      rst_n          = 1'b0;
      fetch_en       = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Reset state
      repeat (3) tick();
      probe(P_MEMPC, 32'h0, "rst_mem_pc");
      probe(P_VLD,   32'h0, "rst_instr_valid");
      probe(P_INSTR, 32'h0, "rst_instr");
      probe(P_IPC,   32'h0, "rst_instr_pc");
      exp_push(32'h0);
      rst_n = 1'b1;
      wait_first("boot_latency");

      // Decode stall with pc 4 at the head
      wait_head(32'h4, "reach_head_4");
      repeat (10) tick();
      probe(P_VLD,   32'h1,        "stall_valid");
      probe(P_IPC,   32'h4,        "stall_head_pc");
      probe(P_INSTR, 32'h04050607, "stall_head_instr");
      probe(P_MEMPC, 32'(4 + 4 * DEPTH), "stall_mem_pc");
      exp_push(32'h4);
      exp_push(32'h8);
      instr_ready = 1'b1;
`ifdef IFETCH_BUF2_EN
      tick();
      probe(P_VLD, 32'h1, "b2b_second_valid");
      probe(P_IPC, 32'h8, "b2b_second_pc");
`endif
      wait_head(32'hC, "reach_head_c");
      repeat (8) tick();

      // Reset for one cycle mid-stream with pc 0xC at the head
      rst_n = 1'b0;
      tick();
      probe(P_MEMPC, 32'h0, "midrst_mem_pc");
      probe(P_VLD,   32'h0, "midrst_instr_valid");
      probe(P_INSTR, 32'h0, "midrst_instr");
      probe(P_IPC,   32'h0, "midrst_instr_pc");
      exp_push(32'h0);
      exp_push(32'h4);
      rst_n       = 1'b1;
      instr_ready = 1'b1;
      wait_first("midrst_latency");
      wait_head(32'h8, "reach_head_8");
      repeat (8) tick();

      // Redirect to 0x10 with entries buffered: they must never appear
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      tick();
      redirect_valid = 1'b0;
      probe(P_VLD,   32'h0,  "redir_valid_drop");
      probe(P_MEMPC, 32'h10, "redir_mem_pc");
      exp_push(32'h10);
      instr_ready = 1'b1;
      wait_first("redir_latency");
      wait_head(32'h14, "reach_head_14");
      repeat (8) tick();

      // Misaligned redirect target
      redirect_valid = 1'b1;
      redirect_pc    = 32'h13;
      tick();
      redirect_valid = 1'b0;
      probe(P_MEMPC, 32'h10, "redir_align_mem_pc");
      exp_push(32'h10);
      exp_push(32'h14);
      instr_ready = 1'b1;
      wait_head(32'h18, "reach_head_18");
      repeat (8) tick();

      // fetch_en low: buffer drains, address frozen
      fetch_en = 1'b0;
      exp_push(32'h18);
`ifdef IFETCH_BUF2_EN
      exp_push(32'h1C);
`endif
      instr_ready = 1'b1;
      repeat (10) tick();
      probe(P_VLD,    32'h0, "freeze_drained");
      probe(P_MEMPC,  32'(32'h18 + 4 * DEPTH), "freeze_mem_pc");
      probe(P_QEMPTY, 32'h0, "scoreboard_empty");
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
